// File: rtl/pong_adc_pkg.sv
// Shared types, default position limits and the clamp helper for the RC-timing paddle ADC.
package pong_adc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DISCH  = 3'd1,
        CHARGE = 3'd2,
        SCALE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int unsigned POS_MIN_DEF  = 0;
    localparam int unsigned POS_MAX_DEF  = 400;
    localparam int unsigned POS_INIT_DEF = 240;

    // Limit v to the closed range [lo, hi]; all operands unsigned.
    function automatic logic [31:0] clamp_u(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/pong_rc_adc_if.sv
// Pin and game-side signal bundle of the paddle ADC.
// slave is the ADC's view, master is the view of whoever drives start and the comparators.
interface pong_rc_adc_if #(
    parameter int NCH = 2,
    parameter int PW  = 10
);
    logic              start;
    logic [NCH-1:0]    cmp_in;
    logic [NCH-1:0]    dischg_out;
    logic [NCH*PW-1:0] pos;
    logic              pos_valid;
    logic [NCH-1:0]    fault;
    logic              busy;

    modport slave (
        input  start,
        input  cmp_in,
        output dischg_out,
        output pos,
        output pos_valid,
        output fault,
        output busy
    );

    modport master (
        output start,
        output cmp_in,
        input  dischg_out,
        input  pos,
        input  pos_valid,
        input  fault,
        input  busy
    );
endinterface

// File: rtl/pong_rc_adc_chan.sv
// One paddle channel: comparator synchroniser, capture of the trip count,
// stuck/timeout flags and the scaled, clamped position candidate.
module rc_adc_chan
    import pong_adc_pkg::*;
#(
    parameter int          CW      = 16,
    parameter int          PW      = 10,
    parameter int          SHIFT   = 6,
    parameter int unsigned POS_MIN = POS_MIN_DEF,
    parameter int unsigned POS_MAX = POS_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmp_in,
    input  state_t        state,
    input  logic [CW-1:0] counter,
    input  logic          disch_last,   // last DISCH cycle
    input  logic          charge_last,  // CHARGE cycle with counter == MAX_CNT
    output logic          done_now,     // captured earlier or on this cycle
    output logic          fault_flag,
    output logic [PW-1:0] s
);

    logic [1:0]    sync_q;
    logic          cmp_s;
    logic          done_q;
    logic          stuck_q;
    logic          to_q;
    logic [CW-1:0] cnt_q;
    logic          capture;

    assign cmp_s    = sync_q[1];
    assign capture  = (state == CHARGE) && cmp_s && !done_q;
    assign done_now = done_q | capture;

    assign fault_flag = stuck_q | to_q;
    assign s = PW'(clamp_u(32'(cnt_q >> SHIFT), 32'(POS_MIN), 32'(POS_MAX)));

    // Synchronise the comparator, capture the first trip and track the per-frame flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_q  <= '0;
            done_q  <= 1'b0;
            stuck_q <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], cmp_in};
            if (state == DISCH && disch_last) begin
                stuck_q <= cmp_s;
                done_q  <= 1'b0;
                to_q    <= 1'b0;
            end else if (state == CHARGE) begin
                if (capture) begin
                    cnt_q  <= counter;
                    done_q <= 1'b1;
                end else if (charge_last && !done_q) begin
                    to_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pong_rc_adc.sv
// Multi-channel RC-timing paddle ADC: shared frame FSM and counter, per-channel
// capture slices, and registered position/fault/valid outputs.
module pong_rc_adc
    import pong_adc_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          CW        = 16,
    parameter int          PW        = 10,
    parameter int          DISCH_CYC = 1024,
    parameter int          MAX_CNT   = 65535,
    parameter int          SHIFT     = 6,
    parameter int unsigned POS_MIN   = POS_MIN_DEF,
    parameter int unsigned POS_MAX   = POS_MAX_DEF,
    parameter int unsigned POS_INIT  = POS_INIT_DEF
) (
    input logic           clk,
    input logic           rst,
    pong_rc_adc_if.slave  bus
);

    localparam logic [CW-1:0] DISCH_LAST = CW'(DISCH_CYC - 1);
    localparam logic [CW-1:0] MAX_C      = CW'(MAX_CNT);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              disch_last;
    logic              charge_last;
    logic [NCH-1:0]    done_now;
    logic [NCH-1:0]    flt;
    logic [PW-1:0]     s_ch [NCH];
    logic [NCH*PW-1:0] pos_q;
    logic [NCH-1:0]    fault_q;
    logic              pos_valid_q;

    assign disch_last  = (cnt_q == DISCH_LAST);
    assign charge_last = (state_q == CHARGE) && (cnt_q == MAX_C);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        rc_adc_chan #(
            .CW      (CW),
            .PW      (PW),
            .SHIFT   (SHIFT),
            .POS_MIN (POS_MIN),
            .POS_MAX (POS_MAX)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cmp_in      (bus.cmp_in[c]),
            .state       (state_q),
            .counter     (cnt_q),
            .disch_last  (disch_last),
            .charge_last (charge_last),
            .done_now    (done_now[c]),
            .fault_flag  (flt[c]),
            .s           (s_ch[c])
        );
    end

    // State and shared counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame sequencing: discharge, timed charge, then one cycle each to scale and publish.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start)
                    state_d = DISCH;
            end
            DISCH: begin
                if (disch_last) begin
                    state_d = CHARGE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHARGE: begin
                if ((&done_now) || charge_last) begin
                    state_d = SCALE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SCALE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Publish positions and faults so they, and the valid pulse, appear during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                pos_q[c*PW +: PW] <= PW'(POS_INIT);
            fault_q     <= '0;
            pos_valid_q <= 1'b0;
        end else begin
            pos_valid_q <= (state_q == SCALE);
            if (state_q == SCALE) begin
                fault_q <= flt;
                for (int c = 0; c < NCH; c++)
                    if (!flt[c])
                        pos_q[c*PW +: PW] <= s_ch[c];
            end
        end
    end

    assign bus.dischg_out = (state_q == CHARGE) ? '0 : '1;
    assign bus.busy       = (state_q != IDLE);
    assign bus.pos        = pos_q;
    assign bus.fault      = fault_q;
    assign bus.pos_valid  = pos_valid_q;

endmodule

// File: tb/tb_pong_rc_adc.sv
// Scoreboard bench for pong_rc_adc: frames are described by per-channel trip cycle
// and stuck flag; a reference model predicts positions/faults, a monitor checks them.
module tb_pong_rc_adc;

    localparam int NCH     = 2;
    localparam int PW      = 10;
    localparam int DCYC    = 8;
    localparam int MAXC    = 1023;
    localparam int PMIN    = 16;
    localparam int PMAX    = 400;
    localparam int PINIT   = 240;
    localparam int NEVER   = 100000;

    typedef struct {
        logic [NCH*PW-1:0] pos;
        logic [NCH-1:0]    fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   mpos [NCH];
    exp_t sb [$];

    pong_rc_adc_if #(.NCH(NCH), .PW(PW)) bus ();

    pong_rc_adc #(
        .NCH(NCH), .CW(16), .PW(PW), .DISCH_CYC(DCYC), .MAX_CNT(MAXC),
        .SHIFT(1), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position from a captured count: halve, then limit to [PMIN, PMAX].
    function automatic int ref_pos(input int cnt);
        int v;
        v = cnt / 2;
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    // Monitor: every pos_valid pulse consumes one predicted result.
    always @(negedge clk) begin
        if (bus.pos_valid) begin
            check("pos_valid_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("pos", 32'(bus.pos), 32'(e.pos));
                check("fault", 32'(bus.fault), 32'(e.fault));
            end
        end
    end

    // One frame: trip cycle t (CHARGE cycle where cmp_in rises) or NEVER, stuck = high through DISCH.
    task automatic run_frame(input int t0, input int t1, input bit s0, input bit s1, input bit ign);
        int  tt [NCH];
        bit  ss [NCH];
        int  cnt [NCH];
        int  mx, ex, k, busy_n, pv_n, pv_at;
        bit  f;
        exp_t e;
        tt[0] = t0; tt[1] = t1; ss[0] = s0; ss[1] = s1;
        mx = 0;
        for (int c = 0; c < NCH; c++) begin
            cnt[c] = ss[c] ? 0 : tt[c] + 2;
            if (cnt[c] > mx) mx = cnt[c];
        end
        ex = (mx > MAXC) ? MAXC : mx;
        e.fault = '0;
        for (int c = 0; c < NCH; c++) begin
            f = ss[c] || (cnt[c] > ex);
            e.fault[c] = f;
            if (!f) mpos[c] = ref_pos(cnt[c]);
        end
        e.pos = {10'(mpos[1]), 10'(mpos[0])};
        sb.push_back(e);
        k = (ign && ex >= 1) ? int'($urandom_range(ex - 1, 0)) : -1;

        for (int c = 0; c < NCH; c++) bus.cmp_in[c] = ss[c];
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n = 0; pv_n = 0; pv_at = -1;
        for (int n = 0; n < ex + 14; n++) begin
            if (bus.busy) busy_n++;
            if (bus.pos_valid) begin pv_n++; pv_at = n; end
            if (n == 0) check("busy_after_start", 32'(bus.busy), 1);
            if (n < DCYC) check("dischg_in_disch", 32'(bus.dischg_out), 32'b11);
            if (n == DCYC) check("dischg_in_charge", 32'(bus.dischg_out), 32'b00);
            for (int c = 0; c < NCH; c++)
                bus.cmp_in[c] = ss[c] || (n >= DCYC && n - DCYC >= tt[c]);
            bus.start = (k >= 0 && n == DCYC + k);
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus.cmp_in = '0;
        check("busy_cycles", 32'(busy_n), 32'(ex + 11));
        check("pos_valid_pulses", 32'(pv_n), 1);
        check("pos_valid_latency", 32'(pv_at), 32'(ex + 10));
        check("scoreboard_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start  = 1'b0;
        bus.cmp_in = '0;
        for (int c = 0; c < NCH; c++) mpos[c] = PINIT;
        repeat (3) @(negedge clk);
        check("rst_dischg", 32'(bus.dischg_out), 32'b11);
        check("rst_pos", 32'(bus.pos), {12'd0, 10'd240, 10'd240});
        check("rst_pos_valid", 32'(bus.pos_valid), 0);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);

        run_frame(298, 98, 0, 0, 0);        // counts 300/100 -> 150/50
        run_frame(10, 900, 0, 0, 0);        // 6 -> 16, 451 -> 400
        run_frame(100, NEVER, 0, 0, 0);     // ch1 times out at 1023
        run_frame(0, 200, 1, 0, 0);         // ch0 stuck
        run_frame(50, 60, 0, 0, 0);         // clean frame clears fault
        run_frame(1021, 1021, 0, 0, 0);     // capture exactly at MAX_CNT
        run_frame(1022, 5, 0, 0, 0);        // one past MAX_CNT times out
        run_frame(500, 30, 0, 0, 1);        // start pulse during CHARGE ignored

        // Reset in the middle of CHARGE discards the conversion.
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (DCYC + 50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_dischg", 32'(bus.dischg_out), 32'b11);
        check("midrst_pos", 32'(bus.pos), {12'd0, 10'd240, 10'd240});
        check("midrst_pos_valid", 32'(bus.pos_valid), 0);
        check("midrst_fault", 32'(bus.fault), 0);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) mpos[c] = PINIT;
        run_frame(400, 700, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            int  a, b;
            bit  sa, sb_, ig;
            a   = ($urandom_range(7, 0) == 0) ? NEVER : int'($urandom_range(1100, 0));
            b   = ($urandom_range(7, 0) == 0) ? NEVER : int'($urandom_range(1100, 0));
            sa  = ($urandom_range(7, 0) == 0);
            sb_ = ($urandom_range(7, 0) == 0);
            ig  = ($urandom_range(1, 0) == 1);
            run_frame(a, b, sa, sb_, ig);
        end

        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
